// File: rtl/present_core_arbiter_pkg.sv
// Shared types and constants for the PRESENT core arbiter.
`ifndef SIZE
`define SIZE 64
`endif
`ifndef KEY_SIZE
`define KEY_SIZE 80
`endif

package present_core_arbiter_pkg;

  localparam int unsigned BLOCK_W              = `SIZE;
  localparam int unsigned KEY_W                = `KEY_SIZE;
  localparam int unsigned PRESENT_CORE_LATENCY = 31;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    RESP
  } arb_state_t;

endpackage

// File: rtl/present_core_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    // Scan N_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = (32'(ptr) + off) % N_REQ;
            if (!found && req[idx[ID_W-1:0]]) begin
                found                  = 1'b1;
                grant[idx[ID_W-1:0]]   = 1'b1;
                grant_idx              = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/present_core_arbiter.sv
// Shares one PRESENT core between N_REQ requesters with round-robin
// arbitration, Enable/Done sequencing, ciphertext capture and a watchdog.
module present_core_arbiter
    import present_core_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned ID_W    = $clog2(N_REQ)
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*KEY_W-1:0]   req_key,
    input  logic [N_REQ*BLOCK_W-1:0] req_plaintext,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [BLOCK_W-1:0]       rsp_ciphertext,
    output logic                     rsp_error,
    output logic                     core_enable,
    output logic [KEY_W-1:0]         core_key,
    output logic [BLOCK_W-1:0]       core_plaintext,
    input  logic                     core_done,
    input  logic [BLOCK_W-1:0]       core_ciphertext,
    output logic                     busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    if (TIMEOUT <= PRESENT_CORE_LATENCY) begin : g_bad_timeout
        $error("TIMEOUT must exceed the PRESENT core latency");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("N_REQ must be in 2..8");
    end

    arb_state_t         state;
    arb_state_t         state_next;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   wd_cnt;
    logic               captured;
    logic               timeout_hit;
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_idx;
    logic [KEY_W-1:0]   sel_key;
    logic [BLOCK_W-1:0] sel_pt;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT - 1));

    // Select the granted requester's key and plaintext slices.
    always_comb begin
        sel_key = '0;
        sel_pt  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_key = req_key[i*KEY_W +: KEY_W];
                sel_pt  = req_plaintext[i*BLOCK_W +: BLOCK_W];
            end
        end
    end

    // Next-state logic plus the combinational handshake and core enable.
    always_comb begin
        state_next  = state;
        req_ready   = '0;
        core_enable = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (!Reset && (|req_valid)) begin
                    req_ready  = grant;
                    state_next = LOAD;
                end
            end
            LOAD: state_next = RUN;
            RUN: begin
                core_enable = 1'b1;
                if (core_done) begin
                    state_next = CAPTURE;
                end else if (timeout_hit) begin
                    state_next = RESP;
                end
            end
            CAPTURE: begin
                core_enable = 1'b1;
                state_next  = RESP;
            end
            RESP: begin
                // Enable stays up until the final-key-added result is sampled,
                // then drops so the core does not keep re-adding the key.
                core_enable = !captured;
                if (rsp_valid && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, job registers, watchdog and response registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            wd_cnt         <= '0;
            captured       <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_ciphertext <= '0;
            rsp_error      <= 1'b0;
            core_key       <= '0;
            core_plaintext <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        core_key       <= sel_key;
                        core_plaintext <= sel_pt;
                        rsp_id         <= grant_idx;
                        rsp_error      <= 1'b0;
                        rsp_ciphertext <= '0;
                        rr_ptr         <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                LOAD: begin
                    wd_cnt   <= '0;
                    captured <= 1'b0;
                end
                RUN: begin
                    if (!core_done) begin
                        if (timeout_hit) begin
                            wd_cnt         <= CNT_W'(TIMEOUT);
                            rsp_error      <= 1'b1;
                            rsp_ciphertext <= '0;
                            rsp_valid      <= 1'b1;
                            captured       <= 1'b1;
                        end else if (wd_cnt < CNT_W'(TIMEOUT)) begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    // First RESP cycle samples the core one clock after the
                    // CAPTURE edge committed the final AddRoundKey.
                    if (!captured) begin
                        rsp_ciphertext <= core_ciphertext;
                        rsp_valid      <= 1'b1;
                        captured       <= 1'b1;
                    end else if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present_core_arbiter.sv
// Scoreboard bench for present_core_arbiter with a behavioural PRESENT-80 core.
`timescale 1ns/1ps
module tb_present_core_arbiter;
    import present_core_arbiter_pkg::*;

    localparam int unsigned N_REQ   = 2;
    localparam int unsigned TIMEOUT = 40;
    localparam int unsigned ID_W    = 1;
    localparam int          NOM_LAT = 34;

    logic                     Clock = 1'b0;
    logic                     Reset;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*80-1:0]      req_key;
    logic [N_REQ*64-1:0]      req_plaintext;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [63:0]              rsp_ciphertext;
    logic                     rsp_error;
    logic                     core_enable;
    logic [79:0]              core_key;
    logic [63:0]              core_plaintext;
    logic                     core_done;
    logic [63:0]              core_ciphertext;
    logic                     busy;

    present_core_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT),
        .ID_W    (ID_W)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_key         (req_key),
        .req_plaintext   (req_plaintext),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_ciphertext  (rsp_ciphertext),
        .rsp_error       (rsp_error),
        .core_enable     (core_enable),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_done       (core_done),
        .core_ciphertext (core_ciphertext),
        .busy            (busy)
    );

    always #5 Clock = ~Clock;

    // ---------------- PRESENT-80 reference functions ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] sp_layer(input logic [63:0] x);
        logic [63:0] s, p;
        for (int i = 0; i < 16; i++) s[i*4 +: 4] = sbox(x[i*4 +: 4]);
        p = '0;
        for (int i = 0; i < 63; i++) p[(i*16) % 63] = s[i];
        p[63] = s[63];
        return p;
    endfunction

    function automatic logic [79:0] key_update(input logic [79:0] k, input int rc);
        logic [79:0] r;
        logic [31:0] rcv;
        rcv = rc;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox(r[79:76]);
        r[19:15] = r[19:15] ^ rcv[4:0];
        return r;
    endfunction

    function automatic logic [63:0] present80(input logic [79:0] key, input logic [63:0] pt);
        logic [63:0] st;
        logic [79:0] k;
        st = pt;
        k  = key;
        for (int r = 1; r <= 31; r++) begin
            st = sp_layer(st ^ k[79:16]);
            k  = key_update(k, r);
        end
        return st ^ k[79:16];
    endfunction

    // ---------------- behavioural core: Enable low reloads, Done near the end ----------------
    logic [63:0] c_st  = '0;
    logic [79:0] c_k   = '0;
    int          c_cnt = 0;
    logic        stall = 1'b0;

    always @(posedge Clock) begin
        if (core_enable !== 1'b1) begin
            c_st  <= core_plaintext;
            c_k   <= core_key;
            c_cnt <= 0;
        end else if (c_cnt < 31) begin
            c_st  <= sp_layer(c_st ^ c_k[79:16]);
            c_k   <= key_update(c_k, c_cnt + 1);
            c_cnt <= c_cnt + 1;
        end else begin
            c_st <= c_st ^ c_k[79:16];
        end
    end

    assign core_done       = !stall && (c_cnt >= 30);
    assign core_ciphertext = c_st;

    // ---------------- scoreboard and model state ----------------
    typedef struct {
        int unsigned id;
        logic [79:0] key;
        logic [63:0] pt;
        logic [63:0] ct;
    } job_t;

    typedef struct {
        int unsigned id;
        logic [63:0] ct;
        logic        err;
    } exp_t;

    job_t        jq[$];
    exp_t        sb[$];
    int unsigned g_log[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;
    logic        m_busy   = 1'b0;
    int unsigned m_ptr    = 0;
    int          m_acc    = 0;
    int          m_lat    = NOM_LAT;
    int unsigned bp_left  = 0;
    logic        rst_req  = 1'b0;
    logic        post_rst = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic job_t mk_job(input int unsigned id);
        job_t        j;
        logic [31:0] a, b, c, d, e;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom; e = $urandom;
        j.id  = id;
        j.key = {a, b, c[15:0]};
        j.pt  = {d, e};
        j.ct  = present80(j.key, j.pt);
        return j;
    endfunction

    // Called at the falling edge: compare DUT against the model, then advance the model.
    task automatic monitor();
        logic [N_REQ-1:0] exp_ready;
        logic             exp_valid;
        int unsigned      g, idx;
        exp_ready = '0;
        g         = 0;
        if (!Reset && !m_busy && req_valid != '0) begin
            for (int unsigned o = 0; o < N_REQ; o++) begin
                idx = (m_ptr + o) % N_REQ;
                if (req_valid[idx] && exp_ready == '0) begin
                    exp_ready[idx] = 1'b1;
                    g = idx;
                end
            end
        end
        exp_valid = m_busy && ((cyc - m_acc) >= m_lat);

        check_value("req_ready", 80'(req_ready), 80'(exp_ready));
        check_value("busy", 80'(busy), 80'(m_busy));
        check_value("rsp_valid", 80'(rsp_valid), 80'(exp_valid));
        if (exp_valid && sb.size() > 0) begin
            check_value("rsp_id", 80'(rsp_id), 80'(sb[0].id));
            check_value("rsp_ciphertext", 80'(rsp_ciphertext), 80'(sb[0].ct));
            check_value("rsp_error", 80'(rsp_error), 80'(sb[0].err));
        end
        if (post_rst) begin
            check_value("rst_rsp_id", 80'(rsp_id), 80'd0);
            check_value("rst_rsp_ct", 80'(rsp_ciphertext), 80'd0);
            check_value("rst_rsp_error", 80'(rsp_error), 80'd0);
            check_value("rst_core_enable", 80'(core_enable), 80'd0);
            check_value("rst_core_key", core_key, 80'd0);
            check_value("rst_core_pt", 80'(core_plaintext), 80'd0);
            post_rst = 1'b0;
        end

        if (!Reset && req_ready != '0) begin
            for (int unsigned i = 0; i < N_REQ; i++) if (req_ready[i]) g_log.push_back(i);
        end

        if (Reset) begin
            sb.delete();
            m_busy   = 1'b0;
            m_ptr    = 0;
            post_rst = 1'b1;
        end else if (exp_ready != '0) begin
            for (int k = 0; k < jq.size(); k++) begin
                if (jq[k].id == g) begin
                    sb.push_back('{g, stall ? 64'h0 : jq[k].ct, stall});
                    jq.delete(k);
                    break;
                end
            end
            m_busy = 1'b1;
            m_acc  = cyc + 1;
            m_lat  = stall ? int'(TIMEOUT) + 1 : NOM_LAT;
            m_ptr  = (g + 1) % N_REQ;
        end else if (exp_valid && rsp_ready) begin
            if (sb.size() > 0) sb.delete(0);
            m_busy = 1'b0;
        end else if (exp_valid && bp_left > 0) begin
            bp_left--;
        end
    endtask

    // Called just after the rising edge: present the head job of each requester.
    task automatic drive();
        int unsigned id;
        Reset         = rst_req;
        rst_req       = 1'b0;
        rsp_ready     = (bp_left == 0);
        req_valid     = '0;
        req_key       = '0;
        req_plaintext = '0;
        for (int k = jq.size() - 1; k >= 0; k--) begin
            id = jq[k].id;
            req_valid[id]             = 1'b1;
            req_key[id*80 +: 80]      = jq[k].key;
            req_plaintext[id*64 +: 64] = jq[k].pt;
        end
    endtask

    task automatic step();
        @(negedge Clock);
        monitor();
        @(posedge Clock);
        #1;
        drive();
    endtask

    task automatic wait_idle(input int unsigned budget, input string tag);
        int unsigned n;
        n = 0;
        while ((jq.size() != 0 || m_busy) && n < budget) begin
            step();
            n++;
        end
        step();
        check_value({tag, "_completed"}, 80'(jq.size() == 0 && !m_busy), 80'd1);
    endtask

    initial begin
        int unsigned n;
        Reset         = 1'b1;
        req_valid     = '0;
        req_key       = '0;
        req_plaintext = '0;
        rsp_ready     = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Reset    = 1'b0;
        post_rst = 1'b1;

        // Known-answer vectors
        jq.push_back('{0, 80'h0, 64'h0, 64'h5579C1387B228445});
        wait_idle(100, "kat_zero_r0");
        jq.push_back('{1, {80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2});
        wait_idle(100, "kat_ones_r1");

        // Both requesters valid continuously: grants must alternate
        g_log.delete();
        for (int unsigned i = 0; i < 4; i++) jq.push_back(mk_job(i % 2));
        wait_idle(400, "alternate");
        check_value("alt_count", 80'(g_log.size()), 80'd4);
        for (int i = 0; i < g_log.size() && i < 4; i++) check_value("alt_grant", 80'(g_log[i]), 80'(i % 2));

        // Back-pressure: 20 cycles of rsp_ready low with a second job waiting
        bp_left = 20;
        jq.push_back(mk_job(0));
        jq.push_back(mk_job(1));
        wait_idle(300, "backpressure");

        // Watchdog: core never raises Done
        stall = 1'b1;
        jq.push_back(mk_job(1));
        wait_idle(100, "timeout");
        stall = 1'b0;

        // Reset in the middle of RUN drops the job silently
        jq.push_back(mk_job(0));
        n = 0;
        while (!m_busy && n < 20) begin step(); n++; end
        check_value("rst_job_started", 80'(m_busy), 80'd1);
        repeat (15) step();
        rst_req = 1'b1;
        repeat (60) step();
        jq.push_back(mk_job(1));
        wait_idle(100, "after_reset");

        // Random mix of requesters
        for (int i = 0; i < 6; i++) jq.push_back(mk_job($urandom_range(0, N_REQ - 1)));
        wait_idle(600, "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/present_core_arbiter.md
Name: present_core_arbiter

Overview:
- Shares one PRESENT encryption core between N_REQ independent requesters.
- Accepts (key, plaintext) jobs via per-requester valid/ready and picks one round-robin.
- Sequences the core's Enable/Done protocol, captures the ciphertext and returns it on a single tagged response channel.
- Includes a watchdog that aborts a job if the core never reports Done.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT, 40, maximum RUN cycles before abort. Must be greater than the 31-cycle core latency.
- ID_W, $clog2(N_REQ), width of the response requester tag.

Ports:
- Clock  in  1  single clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  job offered by requester i.
- req_ready  out  N_REQ  one-hot; job i accepted this cycle.
- req_key  in  N_REQ*`key_size  packed 80-bit keys; slice i belongs to requester i.
- req_plaintext  in  N_REQ*`size  packed 64-bit plaintexts.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_ciphertext  out  `size  result.
- rsp_error  out  1  1 = watchdog abort; rsp_ciphertext is 0 in that case.
- core_enable  out  1  drives the core Enable input. Low means the core reloads plaintext and clears its round count.
- core_key  out  `key_size  registered job key.
- core_plaintext  out  `size  registered job plaintext.
- core_done  in  1  core Done.
- core_ciphertext  in  `size  core ciphertext output.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, high) values: state=IDLE; rr_ptr=0; all outputs 0 (req_ready, rsp_valid, rsp_id, rsp_ciphertext, rsp_error, core_enable, core_key, core_plaintext, busy).
- Reset mid-job drops the job with no response. core_enable=0 then puts the core back into load state.
- States: IDLE -> LOAD -> RUN -> CAPTURE -> RESP -> IDLE. RUN can also exit to RESP on timeout.
- IDLE:
  - If any req_valid is set, pick the first set bit at or after rr_ptr, wrapping modulo N_REQ.
  - Assert req_ready[i] combinationally for exactly that i in that cycle.
  - Register key, plaintext and id.
  - Set rr_ptr=(i+1) mod N_REQ.
  - Go to LOAD.
  - req_ready is 0 in every other state. There is no job queue.
- LOAD:
  - core_enable=0 for exactly 1 cycle so the core latches core_plaintext and clears its count.
  - Go to RUN.
- RUN:
  - core_enable=1 and the watchdog counter increments each cycle.
  - If core_done=1, go to CAPTURE.
  - Else if the counter reaches TIMEOUT, set rsp_error=1, rsp_ciphertext=0, and go to RESP.
- CAPTURE:
  - core_enable stays 1 for this one cycle; the core commits its final AddRoundKey on this edge.
  - Next cycle go to RESP and register rsp_ciphertext from core_ciphertext as sampled in RESP's first cycle.
  - Simpler equivalent: latch core_ciphertext at the end of CAPTURE+1.
  - Required fact: the captured value is the core output exactly one clock after core_done first rose, never later. Later samples would re-add the final key.
  - core_enable drops to 0 once the capture occurs.
- RESP:
  - rsp_valid=1. rsp_id, rsp_ciphertext and rsp_error are held stable until rsp_ready=1.
  - On the rsp_valid & rsp_ready cycle: clear rsp_valid and go to IDLE.
  - The next arbitration happens in the IDLE cycle after that, so there is at least 1 idle cycle between jobs.
- Nominal latency, accept to rsp_valid: 1 (LOAD) + 31 (RUN until Done) + 1 (CAPTURE) + 1 = 34 cycles.
- core_done=1 observed during LOAD is ignored; this is stale status from the previous job.
- req_valid may drop without handshake; an unaccepted request carries no obligation.
- Requesters must hold req_key/req_plaintext stable while req_valid is high.
- All arithmetic is unsigned. The watchdog counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

Decomposition:
- Shared package (alongside the existing `size/`key_size constants): arb_state_t enum {IDLE, LOAD, RUN, CAPTURE, RESP}, and a PRESENT_CORE_LATENCY=31 constant used for the TIMEOUT sanity check.
- One sub-module, rr_pick:
  - Inputs: N_REQ-bit request vector and rr_ptr.
  - Outputs: one-hot grant plus grant index.
  - Purely combinational, reusable elsewhere.
- The arbiter instantiates the existing Encrypt core only in the bench harness; the RTL exposes core_* ports.

Test Plan:
- Single job, requester 0: key=80'h0, plaintext=64'h0 -> rsp_valid 34 cycles after accept, rsp_id=0, rsp_ciphertext=64'h5579C1387B228445, rsp_error=0.
- Key all-ones: key=80'hFFFF_FFFF_FFFF_FFFF_FFFF, plaintext=64'hFFFF_FFFF_FFFF_FFFF via requester 1 -> rsp_ciphertext=64'h3333DCD3213210D2, rsp_id=1.
- Both requesters valid continuously, rr_ptr=0 -> grants alternate 0,1,0,1 over 4 jobs; no requester is granted twice in a row.
- Back-pressure: hold rsp_ready=0 for 20 cycles -> rsp_valid, rsp_id and rsp_ciphertext stay stable; req_ready stays 0; release -> IDLE, next grant one cycle later.
- Timeout: stub core with core_done tied 0, TIMEOUT=40 -> rsp_valid=1 with rsp_error=1 and rsp_ciphertext=0 after 1+40 cycles in LOAD/RUN.
- Reset asserted mid-RUN (cycle 15) -> next cycle all outputs 0 and state IDLE; no rsp_valid ever appears for the aborted job; a new job afterwards returns the correct ciphertext.
